// File: rtl/fft_butterfly_r4_if.sv
// fft_butterfly_r4_if: bundles the radix-4 butterfly's input vector, per-vector
// controls and result vector into one bus.
//   master : drives iVALID/iINV/iSHIFT/iCLR_OVF/iX*, observes oVALID/oY*/oOVF
//   slave  : the butterfly itself (inputs in, results out)
// BIT is the width of every signed real/imag sample.
interface fft_butterfly_r4_if #(
  parameter int unsigned BIT = 17
);

  logic                  iVALID;
  logic                  iINV;
  logic [1:0]            iSHIFT;
  logic                  iCLR_OVF;
  logic signed [BIT-1:0] iX0_RE;
  logic signed [BIT-1:0] iX0_IM;
  logic signed [BIT-1:0] iX1_RE;
  logic signed [BIT-1:0] iX1_IM;
  logic signed [BIT-1:0] iX2_RE;
  logic signed [BIT-1:0] iX2_IM;
  logic signed [BIT-1:0] iX3_RE;
  logic signed [BIT-1:0] iX3_IM;

  logic                  oVALID;
  logic signed [BIT-1:0] oY0_RE;
  logic signed [BIT-1:0] oY0_IM;
  logic signed [BIT-1:0] oY1_RE;
  logic signed [BIT-1:0] oY1_IM;
  logic signed [BIT-1:0] oY2_RE;
  logic signed [BIT-1:0] oY2_IM;
  logic signed [BIT-1:0] oY3_RE;
  logic signed [BIT-1:0] oY3_IM;
  logic                  oOVF;

  modport master (
    output iVALID, iINV, iSHIFT, iCLR_OVF,
    output iX0_RE, iX0_IM, iX1_RE, iX1_IM, iX2_RE, iX2_IM, iX3_RE, iX3_IM,
    input  oVALID, oOVF,
    input  oY0_RE, oY0_IM, oY1_RE, oY1_IM, oY2_RE, oY2_IM, oY3_RE, oY3_IM
  );

  modport slave (
    input  iVALID, iINV, iSHIFT, iCLR_OVF,
    input  iX0_RE, iX0_IM, iX1_RE, iX1_IM, iX2_RE, iX2_IM, iX3_RE, iX3_IM,
    output oVALID, oOVF,
    output oY0_RE, oY0_IM, oY1_RE, oY1_IM, oY2_RE, oY2_IM, oY3_RE, oY3_IM
  );

endinterface

// File: rtl/fft_butterfly_r4.sv
// fft_butterfly_r4: radix-4 DIT butterfly, three register stages, one vector
// per cycle, no backpressure.
//   Stage 1: a = x0+x2, b = x0-x2, c = x1+x3, d = x1-x3 (BIT+1 bits)
//   Stage 2: y0 = a+c, y2 = a-c, y1/y3 = b -/+ j*d (swapped when inverse)
//   Stage 3: arithmetic right shift by min(iSHIFT,2), saturate to BIT bits,
//            sticky overflow flag (set wins over iCLR_OVF)
// Ports:
//   iCLK   : clock, rising edge
//   iRESET : synchronous active-high reset, clears valids, data and oOVF
//   bus    : fft_butterfly_r4_if.slave (inputs x0..x3, controls, y0..y3)
// Build option: define FFT_BF4_ROUND_EN to add 2^(s-1) before the shift
// (round half toward +inf); otherwise the shift truncates toward -inf.
module fft_butterfly_r4 #(
  parameter int unsigned BIT = 17
) (
  input  logic              iCLK,
  input  logic              iRESET,
  fft_butterfly_r4_if.slave bus
);

  localparam int unsigned W1 = BIT + 1;
  localparam int unsigned W2 = BIT + 2;
  localparam int unsigned W3 = BIT + 3;

  localparam logic signed [W3-1:0] SAT_MAX = (W3'(1) <<< (BIT - 1)) - W3'(1);
  localparam logic signed [W3-1:0] SAT_MIN = -(W3'(1) <<< (BIT - 1));

  // Input vector unpacked for indexed access
  logic signed [BIT-1:0] xRe [4];
  logic signed [BIT-1:0] xIm [4];

  assign xRe[0] = bus.iX0_RE;
  assign xIm[0] = bus.iX0_IM;
  assign xRe[1] = bus.iX1_RE;
  assign xIm[1] = bus.iX1_IM;
  assign xRe[2] = bus.iX2_RE;
  assign xIm[2] = bus.iX2_IM;
  assign xRe[3] = bus.iX3_RE;
  assign xIm[3] = bus.iX3_IM;

  // ---------------------------------------------------------------- stage 1
  // Index 0..3 holds a, b, c, d.
  logic                 s1Valid;
  logic                 s1Inv;
  logic [1:0]           s1Shift;
  logic signed [W1-1:0] s1Re [4];
  logic signed [W1-1:0] s1Im [4];

  // First butterfly layer; shift of 3 is folded to 2 here so later stages see 0..2
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      s1Valid <= 1'b0;
      s1Inv   <= 1'b0;
      s1Shift <= 2'd0;
      for (int k = 0; k < 4; k++) begin
        s1Re[k] <= '0;
        s1Im[k] <= '0;
      end
    end else begin
      s1Valid <= bus.iVALID;
      s1Inv   <= bus.iINV;
      s1Shift <= (bus.iSHIFT == 2'd3) ? 2'd2 : bus.iSHIFT;
      s1Re[0] <= W1'(xRe[0]) + W1'(xRe[2]);
      s1Im[0] <= W1'(xIm[0]) + W1'(xIm[2]);
      s1Re[1] <= W1'(xRe[0]) - W1'(xRe[2]);
      s1Im[1] <= W1'(xIm[0]) - W1'(xIm[2]);
      s1Re[2] <= W1'(xRe[1]) + W1'(xRe[3]);
      s1Im[2] <= W1'(xIm[1]) + W1'(xIm[3]);
      s1Re[3] <= W1'(xRe[1]) - W1'(xRe[3]);
      s1Im[3] <= W1'(xIm[1]) - W1'(xIm[3]);
    end
  end

  // ---------------------------------------------------------------- stage 2
  // b - j*d and b + j*d; the direction bit only picks which lands on y1 vs y3.
  logic signed [W2-1:0] bMjRe;
  logic signed [W2-1:0] bMjIm;
  logic signed [W2-1:0] bPjRe;
  logic signed [W2-1:0] bPjIm;

  always_comb begin
    bMjRe = W2'(s1Re[1]) + W2'(s1Im[3]);
    bMjIm = W2'(s1Im[1]) - W2'(s1Re[3]);
    bPjRe = W2'(s1Re[1]) - W2'(s1Im[3]);
    bPjIm = W2'(s1Im[1]) + W2'(s1Re[3]);
  end

  logic                 s2Valid;
  logic [1:0]           s2Shift;
  logic signed [W2-1:0] s2Re [4];
  logic signed [W2-1:0] s2Im [4];

  // Second butterfly layer, full-precision results y0..y3
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      s2Valid <= 1'b0;
      s2Shift <= 2'd0;
      for (int k = 0; k < 4; k++) begin
        s2Re[k] <= '0;
        s2Im[k] <= '0;
      end
    end else begin
      s2Valid <= s1Valid;
      s2Shift <= s1Shift;
      s2Re[0] <= W2'(s1Re[0]) + W2'(s1Re[2]);
      s2Im[0] <= W2'(s1Im[0]) + W2'(s1Im[2]);
      s2Re[2] <= W2'(s1Re[0]) - W2'(s1Re[2]);
      s2Im[2] <= W2'(s1Im[0]) - W2'(s1Im[2]);
      s2Re[1] <= s1Inv ? bPjRe : bMjRe;
      s2Im[1] <= s1Inv ? bPjIm : bMjIm;
      s2Re[3] <= s1Inv ? bMjRe : bPjRe;
      s2Im[3] <= s1Inv ? bMjIm : bPjIm;
    end
  end

  // ---------------------------------------------------------------- stage 3
  // Components 0..3 are the real parts of y0..y3, 4..7 the imaginary parts.
  logic signed [W2-1:0]  comp   [8];
  logic signed [W3-1:0]  extV   [8];
  logic signed [W3-1:0]  rndV   [8];
  logic signed [W3-1:0]  shfV   [8];
  logic signed [BIT-1:0] scaled [8];
  logic [7:0]            satHit;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      comp[k]     = s2Re[k];
      comp[k + 4] = s2Im[k];
    end
  end

`ifdef FFT_BF4_ROUND_EN
  // Half an LSB of the shifted result; W3 leaves headroom so the add never wraps
  logic signed [W3-1:0] roundAdd;

  always_comb begin
    roundAdd = W3'(0);
    if (s2Shift != 2'd0) begin
      roundAdd = W3'(1) <<< (s2Shift - 2'd1);
    end
  end
`endif

  // Optional round, arithmetic shift, then clamp to the BIT-bit signed range
  always_comb begin
    satHit = 8'd0;
    for (int k = 0; k < 8; k++) begin
      extV[k] = W3'(comp[k]);
`ifdef FFT_BF4_ROUND_EN
      rndV[k] = extV[k] + roundAdd;
`else
      rndV[k] = extV[k];
`endif
      shfV[k] = rndV[k] >>> s2Shift;
      if (shfV[k] > SAT_MAX) begin
        scaled[k] = SAT_MAX[BIT-1:0];
        satHit[k] = 1'b1;
      end else if (shfV[k] < SAT_MIN) begin
        scaled[k] = SAT_MIN[BIT-1:0];
        satHit[k] = 1'b1;
      end else begin
        scaled[k] = shfV[k][BIT-1:0];
      end
    end
  end

  logic                  s3Valid;
  logic signed [BIT-1:0] s3Re [4];
  logic signed [BIT-1:0] s3Im [4];
  logic                  ovfReg;

  // Output register; only a valid vector may set the sticky flag, and a set
  // on the same edge as a clear wins
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      s3Valid <= 1'b0;
      ovfReg  <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        s3Re[k] <= '0;
        s3Im[k] <= '0;
      end
    end else begin
      s3Valid <= s2Valid;
      for (int k = 0; k < 4; k++) begin
        s3Re[k] <= scaled[k];
        s3Im[k] <= scaled[k + 4];
      end
      if (s2Valid && (|satHit)) begin
        ovfReg <= 1'b1;
      end else if (bus.iCLR_OVF) begin
        ovfReg <= 1'b0;
      end
    end
  end

  assign bus.oVALID = s3Valid;
  assign bus.oOVF   = ovfReg;
  assign bus.oY0_RE = s3Re[0];
  assign bus.oY0_IM = s3Im[0];
  assign bus.oY1_RE = s3Re[1];
  assign bus.oY1_IM = s3Im[1];
  assign bus.oY2_RE = s3Re[2];
  assign bus.oY2_IM = s3Im[2];
  assign bus.oY3_RE = s3Re[3];
  assign bus.oY3_IM = s3Im[3];

endmodule

// File: tb/tb_fft_butterfly_r4.sv
// tb_fft_butterfly_r4: drives directed and random vectors into
// fft_butterfly_r4 and checks every cycle against a 4-point DFT model with
// scaling/saturation, plus hand-computed literal expectations.
module tb_fft_butterfly_r4;

  localparam int unsigned BIT = 17;
  localparam int MAXV = (1 << (BIT - 1)) - 1;
  localparam int MINV = -(1 << (BIT - 1));

  logic iCLK = 1'b0;
  logic iRESET;

  always #5 iCLK = ~iCLK;

  fft_butterfly_r4_if #(.BIT(BIT)) bus ();

  fft_butterfly_r4 #(.BIT(BIT)) dut (
    .iCLK   (iCLK),
    .iRESET (iRESET),
    .bus    (bus)
  );

  int nTests = 0;
  int nFail  = 0;
  bit checkEn = 1'b0;

  logic signed [BIT-1:0] dRe [4];
  logic signed [BIT-1:0] dIm [4];
  assign dRe[0] = bus.oY0_RE;
  assign dIm[0] = bus.oY0_IM;
  assign dRe[1] = bus.oY1_RE;
  assign dIm[1] = bus.oY1_IM;
  assign dRe[2] = bus.oY2_RE;
  assign dIm[2] = bus.oY2_IM;
  assign dRe[3] = bus.oY3_RE;
  assign dIm[3] = bus.oY3_IM;

  typedef struct packed {
    logic                v;
    logic                sat;
    logic [3:0][BIT-1:0] re;
    logic [3:0][BIT-1:0] im;
  } ent_t;

  task automatic chk(input string nm, input int act, input int exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Shift (with optional rounding) and clamp one full-precision value
  function automatic int scaleOne(input int v, input int s, output bit sat);
    int r;
    r = v;
`ifdef FFT_BF4_ROUND_EN
    if (s > 0) r = r + (1 << (s - 1));
`endif
    r = r >>> s;
    sat = 1'b0;
    if (r > MAXV) begin
      r = MAXV;
      sat = 1'b1;
    end else if (r < MINV) begin
      r = MINV;
      sat = 1'b1;
    end
    return r;
  endfunction

  // y_k = sum_n x_n * W^(n*k), W = -j forward, +j inverse
  function automatic ent_t refVec(input int xr[4], input int xi[4], input bit v,
                                  input bit inv, input int sh);
    ent_t e;
    int s, accR, accI, wr, wi, m, t;
    bit st;
    e = '0;
    e.v = v;
    s = (sh > 2) ? 2 : sh;
    for (int k = 0; k < 4; k++) begin
      accR = 0;
      accI = 0;
      for (int n = 0; n < 4; n++) begin
        m = (n * k) % 4;
        case (m)
          0:       begin wr = 1;  wi = 0; end
          1:       begin wr = 0;  wi = inv ? 1 : -1; end
          2:       begin wr = -1; wi = 0; end
          default: begin wr = 0;  wi = inv ? -1 : 1; end
        endcase
        accR += xr[n] * wr - xi[n] * wi;
        accI += xr[n] * wi + xi[n] * wr;
      end
      t = scaleOne(accR, s, st);
      e.re[k] = BIT'(t);
      e.sat |= st;
      t = scaleOne(accI, s, st);
      e.im[k] = BIT'(t);
      e.sat |= st;
    end
    return e;
  endfunction

  // Reference pipeline: queue holds the two vectors inside the block
  ent_t q[$];
  ent_t cur = '0;
  ent_t zeroEnt = '0;
  bit   expOvf = 1'b0;

  always @(posedge iCLK) begin
    int xr[4];
    int xi[4];
    if (iRESET) begin
      q.delete();
      q.push_back(zeroEnt);
      q.push_back(zeroEnt);
      cur = zeroEnt;
      expOvf = 1'b0;
    end else begin
      xr[0] = int'(bus.iX0_RE); xi[0] = int'(bus.iX0_IM);
      xr[1] = int'(bus.iX1_RE); xi[1] = int'(bus.iX1_IM);
      xr[2] = int'(bus.iX2_RE); xi[2] = int'(bus.iX2_IM);
      xr[3] = int'(bus.iX3_RE); xi[3] = int'(bus.iX3_IM);
      q.push_back(refVec(xr, xi, bus.iVALID, bus.iINV, int'(bus.iSHIFT)));
      cur = q.pop_front();
      if (cur.v && cur.sat) expOvf = 1'b1;
      else if (bus.iCLR_OVF) expOvf = 1'b0;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge iCLK) begin
    if (checkEn) begin
      chk("oVALID", int'(bus.oVALID), int'(cur.v));
      chk("oOVF", int'(bus.oOVF), int'(expOvf));
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("y%0d_re", k), int'(dRe[k]), int'($signed(cur.re[k])));
        chk($sformatf("y%0d_im", k), int'(dIm[k]), int'($signed(cur.im[k])));
      end
    end
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic setVec(input bit v, input bit inv, input int sh,
                        input int xr[4], input int xi[4]);
    bus.iVALID = v;
    bus.iINV   = inv;
    bus.iSHIFT = 2'(sh);
    bus.iX0_RE = BIT'(xr[0]); bus.iX0_IM = BIT'(xi[0]);
    bus.iX1_RE = BIT'(xr[1]); bus.iX1_IM = BIT'(xi[1]);
    bus.iX2_RE = BIT'(xr[2]); bus.iX2_IM = BIT'(xi[2]);
    bus.iX3_RE = BIT'(xr[3]); bus.iX3_IM = BIT'(xi[3]);
  endtask

  task automatic idle();
    int z[4];
    z = '{0, 0, 0, 0};
    setVec(1'b0, 1'b0, 0, z, z);
  endtask

  // One vector, then literal checks on the exact output cycle
  task automatic litVec(input string nm, input bit inv, input int sh,
                        input int xr[4], input int xi[4],
                        input int er[4], input int ei[4], input bit eOvf);
    setVec(1'b1, inv, sh, xr, xi);
    tick();
    idle();
    tick();
    chk({nm, " early_valid"}, int'(bus.oVALID), 0);
    tick();
    chk({nm, " valid"}, int'(bus.oVALID), 1);
    chk({nm, " ovf"}, int'(bus.oOVF), int'(eOvf));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s y%0d_re", nm, k), int'(dRe[k]), er[k]);
      chk($sformatf("%s y%0d_im", nm, k), int'(dIm[k]), ei[k]);
    end
  endtask

  initial begin
    int xr[4], xi[4], er[4], ei[4], z[4];
    int pat[6];
    int got[$];
    int gotV[9];
    int val;
    bit [31:0] r;

    z = '{0, 0, 0, 0};
    iRESET = 1'b1;
    bus.iCLR_OVF = 1'b0;
    idle();
    tick();
    checkEn = 1'b1;
    tick();
    iRESET = 1'b0;
    chk("reset valid", int'(bus.oVALID), 0);
    chk("reset ovf", int'(bus.oOVF), 0);
    chk("reset y0_re", int'(dRe[0]), 0);

    // Forward DC
    xr = '{100, 100, 100, 100};
    er = '{400, 0, 0, 0};
    litVec("dc", 1'b0, 0, xr, z, er, z, 1'b0);

    // Rotation, forward and inverse
    xr = '{0, 10, 0, 0};
    er = '{10, 0, -10, 0};
    ei = '{0, -10, 0, 10};
    litVec("rot_fwd", 1'b0, 0, xr, z, er, ei, 1'b0);
    ei = '{0, 10, 0, -10};
    litVec("rot_inv", 1'b1, 0, xr, z, er, ei, 1'b0);

    // Scaling and rounding
    xr = '{3, 0, 0, 0};
`ifdef FFT_BF4_ROUND_EN
    er = '{1, 1, 1, 1};
`else
    er = '{0, 0, 0, 0};
`endif
    litVec("scale_pos", 1'b0, 2, xr, z, er, z, 1'b0);
    xr = '{-3, 0, 0, 0};
    er = '{-1, -1, -1, -1};
    litVec("scale_neg", 1'b0, 2, xr, z, er, z, 1'b0);
    // Shift 3 behaves as 2
    xr = '{8, 0, 0, 0};
    er = '{2, 2, 2, 2};
    litVec("shift3", 1'b0, 3, xr, z, er, z, 1'b0);

    // Saturation, stickiness, clear
    xr = '{40000, 40000, 40000, 40000};
    er = '{65535, 0, 0, 0};
    litVec("sat", 1'b0, 0, xr, z, er, z, 1'b1);
    xr = '{100, 100, 100, 100};
    er = '{400, 0, 0, 0};
    litVec("sticky", 1'b0, 0, xr, z, er, z, 1'b1);
    bus.iCLR_OVF = 1'b1;
    tick();
    bus.iCLR_OVF = 1'b0;
    chk("clr ovf", int'(bus.oOVF), 0);
    xr = '{40000, 40000, 40000, 40000};
    er = '{40000, 0, 0, 0};
    litVec("sat_shift2", 1'b0, 2, xr, z, er, z, 1'b0);
    xr = '{-40000, -40000, -40000, -40000};
    er = '{-65536, 0, 0, 0};
    litVec("sat_neg", 1'b0, 0, xr, z, er, z, 1'b1);
    bus.iCLR_OVF = 1'b1;
    tick();
    bus.iCLR_OVF = 1'b0;

    // Streaming with a bubble
    pat = '{1, 1, 0, 1, 1, 1};
    val = 1;
    for (int c = 0; c < 9; c++) begin
      gotV[c] = int'(bus.oVALID);
      if (bus.oVALID) got.push_back(int'(dRe[0]));
      if (c < 6) begin
        xr = '{(pat[c] != 0) ? val : 99, 0, 0, 0};
        setVec(pat[c] != 0, 1'b0, 0, xr, z);
        if (pat[c] != 0) val++;
      end else begin
        idle();
      end
      tick();
    end
    for (int c = 0; c < 3; c++) chk($sformatf("stream pre%0d", c), gotV[c], 0);
    for (int c = 3; c < 9; c++) chk($sformatf("stream pat%0d", c - 3), gotV[c], pat[c - 3]);
    chk("stream count", got.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stream order%0d", i), (i < got.size()) ? got[i] : -1, i + 1);
    end

    // Reset with three vectors in flight
    for (int i = 0; i < 3; i++) begin
      xr = '{11 + i, 0, 0, 0};
      setVec(1'b1, 1'b0, 0, xr, z);
      tick();
    end
    idle();
    iRESET = 1'b1;
    tick();
    iRESET = 1'b0;
    chk("flush valid", int'(bus.oVALID), 0);
    chk("flush y0_re", int'(dRe[0]), 0);
    xr = '{7, 0, 0, 0};
    er = '{7, 7, 7, 7};
    litVec("post_reset", 1'b0, 0, xr, z, er, z, 1'b0);

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      for (int n = 0; n < 4; n++) begin
        r = $urandom;
        if ($urandom_range(0, 4) == 0) begin
          xr[n] = int'($signed(r[BIT-1:0]));
          xi[n] = int'($signed(r[BIT+13:14]));
        end else begin
          xr[n] = int'($urandom_range(0, 4000)) - 2000;
          xi[n] = int'($urandom_range(0, 4000)) - 2000;
        end
      end
      setVec(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), xr, xi);
      bus.iCLR_OVF = ($urandom_range(0, 7) == 0);
      iRESET = ($urandom_range(0, 99) == 0);
      tick();
    end
    iRESET = 1'b0;
    bus.iCLR_OVF = 1'b0;
    idle();
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
